// File: rtl/can_register_bank.sv
// Addressed CAN controller register bank: RW, RO, W1C-sticky and COR-sticky
// registers with reset-mode write locking, 1-cycle read path and registered irq.
module can_register_bank #(
  parameter int unsigned             WIDTH       = 8,
  parameter int unsigned             DEPTH       = 4,
  parameter int unsigned             AW          = 2,
  parameter logic [DEPTH*WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [2*DEPTH-1:0]      MODE        = '0,
  parameter logic [DEPTH-1:0]        LOCK_MASK   = '0,
  parameter logic [DEPTH-1:0]        IRQ_MASK    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            addr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic                     lock_n,
  input  logic [DEPTH*WIDTH-1:0]   hw_set,
  input  logic [DEPTH*WIDTH-1:0]   hw_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [DEPTH*WIDTH-1:0]   reg_out,
  output logic                     irq
);

  typedef enum logic [1:0] {
    MODE_RW  = 2'd0,
    MODE_RO  = 2'd1,
    MODE_W1C = 2'd2,
    MODE_COR = 2'd3
  } reg_mode_e;

  logic [DEPTH-1:0]       hit;
  logic [DEPTH-1:0]       wr_ok;
  logic [DEPTH*WIDTH-1:0] regs_q;
  logic [DEPTH*WIDTH-1:0] regs_d;
  logic [WIDTH-1:0]       rd_sel;
  logic                   irq_d;

  // Out-of-range addresses match no register, so they write nothing and read 0.
  always_comb begin
    hit   = '0;
    wr_ok = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i]   = (addr == AW'(i));
      wr_ok[i] = we && hit[i] && !(LOCK_MASK[i] && lock_n);
    end
  end

  always_comb begin
    regs_d = regs_q;
    rd_sel = '0;
    irq_d  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (reg_mode_e'(MODE[2*i +: 2]))
        MODE_RW:  if (wr_ok[i]) regs_d[i*WIDTH +: WIDTH] = wr_data;
        MODE_RO:  regs_d[i*WIDTH +: WIDTH] = hw_data[i*WIDTH +: WIDTH];
        // Set is OR-ed in after the clear so a coincident event survives.
        MODE_W1C: regs_d[i*WIDTH +: WIDTH] =
                    (regs_q[i*WIDTH +: WIDTH] & ~(wr_ok[i] ? wr_data : '0))
                    | hw_set[i*WIDTH +: WIDTH];
        MODE_COR: regs_d[i*WIDTH +: WIDTH] = (re && hit[i])
                    ? hw_set[i*WIDTH +: WIDTH]
                    : (regs_q[i*WIDTH +: WIDTH] | hw_set[i*WIDTH +: WIDTH]);
      endcase
      if (IRQ_MASK[i] && ((reg_mode_e'(MODE[2*i +: 2]) == MODE_W1C) ||
                          (reg_mode_e'(MODE[2*i +: 2]) == MODE_COR)))
        irq_d = irq_d | (|regs_d[i*WIDTH +: WIDTH]);
      if (hit[i]) rd_sel = rd_sel | regs_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q   <= RESET_VALUE;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      irq      <= irq_d;
      rd_valid <= re;
      if (re) rd_data <= rd_sel;
    end
  end

  assign reg_out = regs_q;

endmodule

// File: tb/tb_can_register_bank.sv
// Bench for can_register_bank: directed scenarios then random traffic, all
// checked against an array-based behavioural model of the register rules.
module tb_can_register_bank;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned A = 3;
  localparam logic [31:0] RV = 32'h0000A53C;
  localparam logic [7:0]  MD = 8'b11_10_01_00;   // reg3 COR, reg2 W1C, reg1 RO, reg0 RW
  localparam logic [3:0]  LM = 4'b0001;
  localparam logic [3:0]  IM = 4'b0100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [A-1:0]  addr = '0;
  logic          we = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          re = 1'b0;
  logic          lock_n = 1'b1;
  logic [31:0]   hw_set = '0;
  logic [31:0]   hw_data = '0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [31:0]   reg_out;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one byte per register plus read/irq outputs.
  int         m_mode [4] = '{0, 1, 2, 3};
  bit         m_lock [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  bit         m_irqen[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] m_reg  [4];
  logic [7:0] m_rd;
  logic       m_rv;
  logic       m_irq;

  always #5 clk = ~clk;

  can_register_bank #(
    .WIDTH(W), .DEPTH(D), .AW(A), .RESET_VALUE(RV), .MODE(MD),
    .LOCK_MASK(LM), .IRQ_MASK(IM)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wr_data(wr_data), .re(re),
    .lock_n(lock_n), .hw_set(hw_set), .hw_data(hw_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .reg_out(reg_out), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = RV[i*8 +: 8];
    m_rd = 8'h00; m_rv = 1'b0; m_irq = 1'b0;
  endfunction

  function automatic void model_clock();
    logic [7:0] nxt [4];
    bit hit, wacc;
    logic [7:0] set;
    int a;
    a = int'(addr);
    if (re) begin
      m_rd = (a < 4) ? m_reg[a] : 8'h00;
      m_rv = 1'b1;
    end else m_rv = 1'b0;
    m_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit  = (a == i);
      wacc = we && hit && !(m_lock[i] && lock_n);
      set  = hw_set[i*8 +: 8];
      case (m_mode[i])
        0:       nxt[i] = wacc ? wr_data : m_reg[i];
        1:       nxt[i] = hw_data[i*8 +: 8];
        2:       nxt[i] = (m_reg[i] & ~(wacc ? wr_data : 8'h00)) | set;
        default: nxt[i] = (re && hit) ? set : (m_reg[i] | set);
      endcase
      if (m_irqen[i] && nxt[i] != 8'h00) m_irq = 1'b1;
    end
    for (int i = 0; i < 4; i++) m_reg[i] = nxt[i];
  endfunction

  function automatic logic [31:0] model_flat();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples.
  task automatic cycle();
    model_clock();
    @(posedge clk);
    #1;
    check("reg_out", reg_out, model_flat());
    check("rd_valid", {31'b0, rd_valid}, {31'b0, m_rv});
    check("rd_data", {24'b0, rd_data}, {24'b0, m_rd});
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; hw_set = '0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check("rst_reg_out", reg_out, 32'h0000A53C);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b1;
    cycle();

    // Lock: reg0 write dropped in operating mode, accepted in reset mode.
    we = 1'b1; addr = 3'd0; wr_data = 8'h55; lock_n = 1'b1;
    cycle();
    check("lock_drop", {24'b0, reg_out[7:0]}, 32'h3C);
    lock_n = 1'b0;
    cycle();
    check("lock_wr", {24'b0, reg_out[7:0]}, 32'h55);
    we = 1'b0; re = 1'b1;
    cycle();
    check("rw_rd", {24'b0, rd_data}, 32'h55);
    check("rw_rv", {31'b0, rd_valid}, 32'd1);
    re = 1'b0; lock_n = 1'b1;
    cycle();
    check("rv_drop", {31'b0, rd_valid}, 32'd0);

    // W1C with irq.
    hw_set = 32'h0008_0000;
    cycle();
    check("w1c_set", {24'b0, reg_out[23:16]}, 32'h08);
    check("w1c_irq", {31'b0, irq}, 32'd1);
    hw_set = '0; we = 1'b1; addr = 3'd2; wr_data = 8'h08;
    cycle();
    check("w1c_clr", {24'b0, reg_out[23:16]}, 32'h00);
    check("w1c_irq0", {31'b0, irq}, 32'd0);
    we = 1'b0; hw_set = 32'h0008_0000;
    cycle();
    we = 1'b1;
    cycle();
    check("w1c_prio", {24'b0, reg_out[23:16]}, 32'h08);
    hw_set = '0;
    cycle();

    // COR, including an event coincident with the clearing read.
    idle(); hw_set = 32'h8100_0000;
    cycle();
    hw_set = '0; re = 1'b1; addr = 3'd3;
    cycle();
    check("cor_rd", {24'b0, rd_data}, 32'h81);
    check("cor_clr", {24'b0, reg_out[31:24]}, 32'h00);
    hw_set = 32'h0200_0000;
    cycle();
    check("cor_pre", {24'b0, rd_data}, 32'h00);
    check("cor_new", {24'b0, reg_out[31:24]}, 32'h02);
    hw_set = '0;
    cycle();
    check("cor_rd2", {24'b0, rd_data}, 32'h02);

    // RO and out-of-range.
    idle(); hw_data = 32'h0000_7E00;
    cycle();
    re = 1'b1; addr = 3'd1;
    cycle();
    check("ro_rd", {24'b0, rd_data}, 32'h7E);
    re = 1'b0; we = 1'b1; wr_data = 8'hFF; lock_n = 1'b0;
    cycle();
    check("ro_wr", {24'b0, reg_out[15:8]}, 32'h7E);
    we = 1'b0; re = 1'b1; addr = 3'd5;
    cycle();
    check("oor_rd", {24'b0, rd_data}, 32'h00);
    check("oor_rv", {31'b0, rd_valid}, 32'd1);
    re = 1'b0;
    for (int a = 4; a < 8; a++) begin
      we = 1'b1; addr = 3'(a); wr_data = 8'hFF;
      cycle();
    end
    idle(); lock_n = 1'b1;

    // Back-to-back reads with interleaved writes.
    for (int k = 0; k < 12; k++) begin
      re = 1'b1; addr = 3'(k % 4);
      we = k[0]; wr_data = 8'($urandom); lock_n = k[1];
      hw_set = $urandom & $urandom;
      cycle();
    end

    // Asynchronous reset in the middle of a write.
    idle(); hw_set = 32'h0004_0000;
    cycle();
    we = 1'b1; addr = 3'd0; wr_data = 8'h11; lock_n = 1'b0; hw_set = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_reg_out", reg_out, 32'h0000A53C);
    check("arst_rv", {31'b0, rd_valid}, 32'd0);
    check("arst_irq", {31'b0, irq}, 32'd0);
    check("arst_rd", {24'b0, rd_data}, 32'd0);
    #1 rst = 1'b1;
    cycle();
    check("post_rst_wr", {24'b0, reg_out[7:0]}, 32'h11);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      addr    = 3'($urandom_range(0, 7));
      we      = 1'($urandom);
      re      = 1'($urandom);
      wr_data = 8'($urandom);
      lock_n  = ($urandom_range(0, 3) != 0);
      hw_set  = $urandom & $urandom & $urandom;
      hw_data = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
